// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Pointer arithmetic wraps at any depth, including non-power-of-two depths.
package sync_fifo_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 9;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_param.
// One synchronous write port and one asynchronous read port; contents are never reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ALFULL_TH  = 5,
  parameter int ALEMPTY_TH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_vld,
  output logic                      buf_empty,
  output logic                      buf_full,
  output logic                      alfull,
  output logic                      alempty,
  output logic [cnt_w(DEPTH)-1:0]   data_cnt,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALFULL_TH);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(ALEMPTY_TH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt_next;
  logic [DATA_W-1:0] mem_rdata;
  logic              wr_acc, rd_acc;

  // Acceptance uses the registered flags, so a full FIFO rejects writes even during a pop
  assign wr_acc = wr_en & ~buf_full;
  assign rd_acc = rd_en & ~buf_empty;

  always_comb begin
    cnt_next = data_cnt;
    if (wr_acc && !rd_acc)      cnt_next = data_cnt + 1'b1;
    else if (rd_acc && !wr_acc) cnt_next = data_cnt - 1'b1;
  end

  sync_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc & rst_n),
    .waddr(wr_ptr),
    .wdata(din),
    .raddr(rd_ptr),
    .rdata(mem_rdata)
  );

  // Flags are derived from the next count so they line up with data_cnt
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_cnt  <= '0;
      buf_empty <= 1'b1;
      buf_full  <= 1'b0;
      alfull    <= 1'b0;
      alempty   <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), DEPTH));
      data_cnt  <= cnt_next;
      buf_empty <= (cnt_next == '0);
      buf_full  <= (cnt_next == FULL_CNT);
      alfull    <= (cnt_next >= AF_CNT);
      alempty   <= (cnt_next <= AE_CNT);
      overflow  <= wr_en & buf_full;
      underflow <= rd_en & buf_empty;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout     = buf_empty ? '0 : mem_rdata;
  assign dout_vld = ~buf_empty;
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else begin
      dout_vld <= rd_acc;
      if (rd_acc) dout <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: constant vector table, directed corner cases
// and randomized traffic against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int DATA_W     = 4;
  localparam int DEPTH      = 9;
  localparam int ALFULL_TH  = 5;
  localparam int ALEMPTY_TH = 1;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              dout_vld, buf_empty, buf_full, alfull, alempty, overflow, underflow;
  logic [CNT_W-1:0]  data_cnt;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_vld = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

  typedef struct {
    logic rst_n, wr, rd;
    logic [DATA_W-1:0] din;
    int   cnt;
    logic empty, full, af, ae, ovf, unf;
  } vec_t;
  vec_t vecs[14];

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ALFULL_TH(ALFULL_TH), .ALEMPTY_TH(ALEMPTY_TH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .dout_vld(dout_vld), .buf_empty(buf_empty), .buf_full(buf_full),
    .alfull(alfull), .alempty(alempty), .data_cnt(data_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkModel();
    int n;
    n = q.size();
    checkOutput("data_cnt", data_cnt, n);
    checkOutput("buf_empty", buf_empty, n == 0);
    checkOutput("buf_full", buf_full, n == DEPTH);
    checkOutput("alfull", alfull, n >= ALFULL_TH);
    checkOutput("alempty", alempty, n <= ALEMPTY_TH);
    checkOutput("overflow", overflow, m_ovf);
    checkOutput("underflow", underflow, m_unf);
    checkOutput("dout_vld", dout_vld, m_vld);
    checkOutput("dout", dout, m_dout);
    checkOutput("cnt_bound", data_cnt <= DEPTH, 1);
  endtask

  // Drive one cycle, advance the reference model, then sample 1 ns after the edge
  task automatic applyStimulus(input logic r, input logic w, input logic rd, input logic [DATA_W-1:0] d);
    bit was_full, was_empty;
    rst_n = r; wr_en = w; rd_en = rd; din = d;
    if (!r) begin
      q.delete();
      m_dout = '0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ovf = w && was_full;
      m_unf = rd && was_empty;
      m_vld = 1'b0;
      if (rd && !was_empty) begin
        m_dout = q.pop_front();
        m_vld  = 1'b1;
      end
      if (w && !was_full) q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    m_vld  = (q.size() != 0);
    m_dout = (q.size() != 0) ? q[0] : '0;
`endif
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    int widx, cyc, wp, rp;
    logic rdt;

    // Reset, underflow from empty, fill with 0..8, one rejected write
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++)
      vecs[3+i] = '{1'b1, 1'b1, 1'b0, 4'(i), i + 1, 1'b0, (i + 1) == 9,
                    (i + 1) >= 5, (i + 1) <= 1, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'hF, 9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'h0, 9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].din);
      checkOutput("tbl_cnt", data_cnt, vecs[i].cnt);
      checkOutput("tbl_empty", buf_empty, vecs[i].empty);
      checkOutput("tbl_full", buf_full, vecs[i].full);
      checkOutput("tbl_alfull", alfull, vecs[i].af);
      checkOutput("tbl_alempty", alempty, vecs[i].ae);
      checkOutput("tbl_overflow", overflow, vecs[i].ovf);
      checkOutput("tbl_underflow", underflow, vecs[i].unf);
    end

    // Drain the full FIFO; words come back as 0..8
    for (int i = 0; i < 9; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checkOutput("fwft_head", dout, i);
`endif
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_FWFT_EN
      checkOutput("drain_dout", dout, i);
      checkOutput("drain_vld", dout_vld, 1);
`endif
    end

    // Underflow after draining leaves the FIFO empty with no valid data
    applyStimulus(1'b1, 1'b0, 1'b1, '0);
    checkOutput("unf_pulse", underflow, 1);
    checkOutput("unf_vld", dout_vld, 0);
    checkOutput("unf_empty", buf_empty, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("unf_clear", underflow, 0);

    // Stream 30 words with reads on alternate cycles, wrapping the pointers
    widx = 0; cyc = 0; rdt = 1'b0;
    while (widx < 30 && cyc < 200) begin
      if (q.size() != DEPTH) begin
        applyStimulus(1'b1, 1'b1, rdt, 4'(widx));
        widx++;
      end else begin
        applyStimulus(1'b1, 1'b1, rdt, 4'(widx));
      end
      rdt = ~rdt;
      cyc++;
    end
    checkOutput("stream_words", widx, 30);
    cyc = 0;
    while (q.size() != 0 && cyc < 50) begin
      applyStimulus(1'b1, 1'b0, 1'b1, '0);
      cyc++;
    end
    checkOutput("stream_drained", data_cnt, 0);

    // Occupancy 4 with simultaneous read and write holds the count
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'(i + 3));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'(i + 10));
      checkOutput("rw_cnt", data_cnt, 4);
      checkOutput("rw_ovf", overflow, 0);
      checkOutput("rw_unf", underflow, 0);
    end

    // Reset mid-stream discards stored words
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h7);
    checkOutput("midrst_cnt", data_cnt, 0);
    checkOutput("midrst_empty", buf_empty, 1);

`ifdef SYNC_FIFO_FWFT_EN
    applyStimulus(1'b1, 1'b1, 1'b0, 4'hA);
    checkOutput("fwft_first", dout, 4'hA);
    checkOutput("fwft_first_vld", dout_vld, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'h5);
    applyStimulus(1'b1, 1'b0, 1'b1, '0);
    checkOutput("fwft_second", dout, 4'h5);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
`endif

    // Randomized traffic in phases biased toward filling, draining and balance
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0: begin wp = 75; rp = 30; end
        1: begin wp = 30; rp = 75; end
        default: begin wp = 55; rp = 55; end
      endcase
      applyStimulus($urandom_range(0, 149) != 0,
                    $urandom_range(0, 99) < wp,
                    $urandom_range(0, 99) < rp,
                    4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
